// File: rtl/shift_pkg.sv
// Shared types and defaults for the SISO shift-chain controller slice.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_bit_sr.sv
// Bidirectional shift register with parallel load; load wins over shift.
// msb_first=1 shifts toward the MSB (serial bit enters at bit 0), else toward the LSB.
module shift_bit_sr
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             msb_first,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= msb_first ? {q[WIDTH-2:0], ser_in} : {ser_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/siso_shift_ctrl.sv
// Sequencing controller: serialises a TX word onto ser_out for a SISO chain while
// assembling the returning ser_in stream into an RX word.
module siso_shift_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             order_q;
    logic             load;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;

    // Handshakes: a word transfers on a rising edge where valid and ready are both high.
    // out_valid/out_data stay stable until then; in_ready only depends on out_ready (in HOLD).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        shift_en  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit order is frozen at acceptance so msb_first may change freely mid-word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            order_q <= 1'b0;
        end else if (load) begin
            cnt_q   <= '0;
            order_q <= msb_first;
        end else if (shift_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    shift_bit_sr #(.WIDTH(WIDTH)) u_tx_sr (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (in_data),
        .shift     (shift_en),
        .msb_first (order_q),
        .ser_in    (1'b0),
        .q         (tx_sr)
    );

    shift_bit_sr #(.WIDTH(WIDTH)) u_rx_sr (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data ({WIDTH{1'b0}}),
        .shift     (shift_en),
        .msb_first (order_q),
        .ser_in    (ser_in),
        .q         (rx_sr)
    );

    assign ser_out  = shift_en & (order_q ? tx_sr[WIDTH-1] : tx_sr[0]);
    assign out_data = rx_sr;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Self-checking bench for siso_shift_ctrl: directed scenarios plus randomized words
// checked against a bit-stream model of loopback / 4-stage chain.
module tb_siso_shift_ctrl;

    localparam int W           = 4;
    localparam int CHAIN_DEPTH = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         msb_first;
    logic         ser_out;
    logic         shift_en;
    logic         ser_in;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    logic                   loop_mode;
    logic                   chain_clr;
    logic [CHAIN_DEPTH-1:0] chain;

    int           errors;
    int           checks;
    logic [W-1:0] exp_q[$];
    logic         chain_bits[$];

    siso_shift_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msb_first (msb_first),
        .ser_out   (ser_out),
        .shift_en  (shift_en),
        .ser_in    (ser_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // clock / external chain
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (chain_clr) begin
            chain <= '0;
        end else if (shift_en) begin
            chain <= {chain[CHAIN_DEPTH-2:0], ser_out};
        end
    end

    assign ser_in = loop_mode ? ser_out : chain[CHAIN_DEPTH-1];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic tx_bit(input logic [W-1:0] w, input logic m, input int i);
        return m ? w[W-1-i] : w[i];
    endfunction

    function automatic logic [W-1:0] tx_seq(input logic [W-1:0] w, input logic m);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < W; i++) s[W-1-i] = tx_bit(w, m, i);
        return s;
    endfunction

    // The chain always shifts with the DUT; ser_in is either the bit just sent or the chain tail.
    function automatic logic [W-1:0] model_xfer(input logic [W-1:0] w, input logic m, input logic lp);
        logic [W-1:0] r;
        logic         b;
        logic         old;
        logic         got;
        r = '0;
        for (int i = 0; i < W; i++) begin
            b = tx_bit(w, m, i);
            chain_bits.push_back(b);
            old = chain_bits.pop_front();
            got = lp ? b : old;
            if (m) r[W-1-i] = got;
            else   r[i] = got;
        end
        return r;
    endfunction

    // driver tasks (called and returning at posedge + 1)
    task automatic clear_chain();
        chain_clr = 1'b1;
        @(posedge clk); #1;
        chain_clr = 1'b0;
        chain_bits.delete();
        for (int i = 0; i < CHAIN_DEPTH; i++) chain_bits.push_back(1'b0);
    endtask

    task automatic drive_word(input logic [W-1:0] w, input logic m, output bit to);
        int n;
        n = 0;
        in_data   = w;
        msb_first = m;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        to = !in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL reset_ser_out: got %b want 0", ser_out); end
        checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %b want 0", shift_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loopback(input logic [W-1:0] w, input logic m, input logic [W-1:0] exp_seq,
                                 input string tag);
        logic [W-1:0] seq;
        logic [W-1:0] got;
        int           n_shift;
        int           first_valid;
        bit           to;
        loop_mode   = 1'b1;
        out_ready   = 1'b1;
        seq         = '0;
        got         = '0;
        n_shift     = 0;
        first_valid = -1;
        drive_word(w, m, to);
        checks++; if (to) begin errors++; $display("FAIL loop_%s_accept: got timeout want accepted", tag); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (shift_en) begin
                n_shift++;
                seq = {seq[W-2:0], ser_out};
            end
            if (out_valid && first_valid < 0) begin
                first_valid = c;
                got = out_data;
            end
        end
        checks++; if (seq !== exp_seq) begin errors++; $display("FAIL loop_%s_ser_out: got %b want %b", tag, seq, exp_seq); end
        checks++; if (n_shift != W) begin errors++; $display("FAIL loop_%s_shift_cycles: got %0d want %0d", tag, n_shift, W); end
        checks++; if (first_valid != W) begin errors++; $display("FAIL loop_%s_latency: got %0d want %0d", tag, first_valid, W); end
        checks++; if (got !== w) begin errors++; $display("FAIL loop_%s_out_data: got %b want %b", tag, got, w); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit           hist[24];
        logic [W-1:0] got_q[$];
        logic [W-1:0] exp;
        int           idx;
        bit           acc;
        int           first;
        int           p;
        int           run1;
        int           gap;
        int           run2;
        clear_chain();
        loop_mode = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(model_xfer(4'hA, 1'b1, 1'b0));
        exp_q.push_back(model_xfer(4'h5, 1'b1, 1'b0));
        idx       = 0;
        msb_first = 1'b1;
        in_data   = 4'hA;
        in_valid  = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            hist[c] = shift_en;
            if (out_valid && out_ready) got_q.push_back(out_data);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx == 1) in_data = 4'h5;
                else          in_valid = 1'b0;
            end
        end
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL b2b_word_count: got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (got_q[0] !== exp) begin errors++; $display("FAIL b2b_out_data: got %h want %h", got_q[0], exp); end
            void'(got_q.pop_front());
        end
        exp_q.delete();
        first = -1;
        for (int c = 0; c < 24; c++) if (hist[c] && first < 0) first = c;
        p = first; run1 = 0; gap = 0; run2 = 0;
        while (p >= 0 && p < 24 && hist[p]) begin run1++; p++; end
        while (p >= 0 && p < 24 && !hist[p]) begin gap++; p++; end
        while (p >= 0 && p < 24 && hist[p]) begin run2++; p++; end
        checks++;
        if (run1 != W || gap != 1 || run2 != W) begin
            errors++;
            $display("FAIL b2b_burst_gap: got run1=%0d gap=%0d run2=%0d want %0d/1/%0d", run1, gap, run2, W, W);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp1;
        logic [W-1:0] exp2;
        logic [W-1:0] held;
        int           n;
        int           bad_data;
        int           bad_shift;
        int           bad_ready;
        int           bad_valid;
        bit           to;
        loop_mode = 1'b1;
        out_ready = 1'b0;
        exp1 = model_xfer(4'h6, 1'b1, 1'b1);
        exp2 = model_xfer(4'h9, 1'b0, 1'b1);
        drive_word(4'h6, 1'b1, to);
        checks++; if (to) begin errors++; $display("FAIL bp_accept: got timeout want accepted"); end
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        held = out_data;
        checks++; if (held !== exp1) begin errors++; $display("FAIL bp_out_data: got %h want %h", held, exp1); end
        @(posedge clk); #1;
        in_data   = 4'h9;
        msb_first = 1'b0;
        in_valid  = 1'b1;
        bad_data = 0; bad_shift = 0; bad_ready = 0; bad_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_data !== exp1) bad_data++;
            if (shift_en !== 1'b0) bad_shift++;
            if (in_ready !== 1'b0) bad_ready++;
            if (out_valid !== 1'b1) bad_valid++;
            @(posedge clk); #1;
        end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL bp_data_stable: got %0d bad cycles want 0", bad_data); end
        checks++; if (bad_shift != 0) begin errors++; $display("FAIL bp_shift_frozen: got %0d bad cycles want 0", bad_shift); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL bp_in_ready_low: got %0d bad cycles want 0", bad_ready); end
        checks++; if (bad_valid != 0) begin errors++; $display("FAIL bp_valid_held: got %0d bad cycles want 0", bad_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (shift_en !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_released: got shift_en=%b out_valid=%b want 1/0", shift_en, out_valid);
        end
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_data !== exp2 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_word: got %h valid=%b want %h", out_data, out_valid, exp2); end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] exp;
        int           nv;
        int           n;
        bit           to;
        loop_mode = 1'b1;
        out_ready = 1'b1;
        drive_word(4'hC, 1'b1, to);
        checks++; if (to) begin errors++; $display("FAIL rst_accept: got timeout want accepted"); end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, ser_out, shift_en, out_valid, busy} !== 5'b10000 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_async_outputs: got rdy=%b so=%b se=%b ov=%b busy=%b od=%h want 1/0/0/0/0/0",
                     in_ready, ser_out, shift_en, out_valid, busy, out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL rst_no_valid: got %0d valid cycles want 0", nv); end
        @(posedge clk); #1;
        exp = model_xfer(4'h3, 1'b0, 1'b1);
        drive_word(4'h3, 1'b0, to);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_data !== exp || out_valid !== 1'b1) begin errors++; $display("FAIL rst_recover: got %h valid=%b want %h", out_data, out_valid, exp); end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_msb_toggle();
        logic [W-1:0] seq;
        bit           to;
        loop_mode = 1'b1;
        out_ready = 1'b1;
        seq = '0;
        drive_word(4'hD, 1'b1, to);
        for (int c = 0; c < W; c++) begin
            @(negedge clk);
            seq = {seq[W-2:0], ser_out};
            if (c == 0) begin
                @(posedge clk); #1;
                msb_first = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (seq !== tx_seq(4'hD, 1'b1)) begin errors++; $display("FAIL toggle_ser_out: got %b want %b", seq, tx_seq(4'hD, 1'b1)); end
        checks++; if (out_data !== 4'hD || out_valid !== 1'b1) begin errors++; $display("FAIL toggle_out_data: got %h valid=%b want d", out_data, out_valid); end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic [W-1:0] seq;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        logic         m;
        logic         lp;
        int           stall;
        bit           to;
        clear_chain();
        for (int n = 0; n < 24; n++) begin
            w     = W'($urandom_range(0, 15));
            m     = 1'($urandom_range(0, 1));
            lp    = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            loop_mode = lp;
            out_ready = (stall == 0);
            exp_q.push_back(model_xfer(w, m, lp));
            drive_word(w, m, to);
            checks++; if (to) begin errors++; $display("FAIL rand_accept[%0d]: got timeout want accepted", n); end
            msb_first = 1'($urandom_range(0, 1));
            seq = '0;
            for (int c = 0; c < W; c++) begin
                @(negedge clk);
                seq = {seq[W-2:0], ser_out};
            end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rand_valid[%0d]: got %b want 1", n, out_valid); end
            got = out_data;
            exp = exp_q.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL rand_out_data[%0d]: got %h want %h (w=%h m=%b lp=%b)", n, got, exp, w, m, lp); end
            checks++; if (seq !== tx_seq(w, m)) begin errors++; $display("FAIL rand_ser_out[%0d]: got %b want %b", n, seq, tx_seq(w, m)); end
            repeat (stall) @(posedge clk);
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        msb_first = 1'b0;
        out_ready = 1'b1;
        loop_mode = 1'b1;
        chain_clr = 1'b0;
        clear_chain();
        test_reset();
        test_loopback(4'b1011, 1'b1, 4'b1011, "msb");
        test_loopback(4'b1011, 1'b0, 4'b1101, "lsb");
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        test_msb_toggle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/siso_shift_ctrl.md
# siso_shift_ctrl

Sequencing controller for the team's serial-in/serial-out shift-register chain. It accepts a parallel TX word over a valid/ready handshake and shifts it out one bit per clock on `ser_out`, asserting `shift_en` for the external chain. During the same cycles it captures the returning serial stream on `ser_in` and presents the assembled RX word over a second valid/ready handshake. It sits between a parallel word source/sink and a SISO chain such as a 4-stage `d → q4` register, or a direct loopback.

## Interface
Parameters:
- `WIDTH`, default 4: bits per word; legal range ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: bit-counter width.

Ports:
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `in_data` input, `WIDTH` bits: TX word.
- `in_valid` input, 1 bit: TX word offered.
- `in_ready` output, 1 bit: controller can accept a TX word this cycle.
- `msb_first` input, 1 bit: bit order, sampled only at word acceptance.
- `ser_out` output, 1 bit: serial data to the chain's `d` input.
- `shift_en` output, 1 bit: chain shift enable, high only in SHIFT.
- `ser_in` input, 1 bit: serial data returning from the chain (for example `q4`).
- `out_data` output, `WIDTH` bits: assembled RX word.
- `out_valid` output, 1 bit: RX word available.
- `out_ready` input, 1 bit: sink accepts the RX word.
- `busy` output, 1 bit: high whenever state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, HOLD. Encoding is 2 bits.
- **IDLE**
  - `in_ready` = 1.
  - When `in_valid` is high: load `tx_sr` ← `in_data`, latch `order` ← `msb_first`, set `cnt` ← 0, clear `rx_sr`, go to SHIFT.
- **SHIFT**
  - `shift_en` = 1, `in_ready` = 0.
  - `ser_out` = `tx_sr[WIDTH-1]` if `order`, else `tx_sr[0]`.
  - Each edge when `order` = 1: `tx_sr` shifts left, and `rx_sr` ← `{rx_sr[WIDTH-2:0], ser_in}`.
  - Each edge when `order` = 0: `tx_sr` shifts right, and `rx_sr` ← `{ser_in, rx_sr[WIDTH-1:1]}`.
  - `cnt` increments each edge. On the edge where `cnt` = `WIDTH-1`, go to HOLD.
- **HOLD**
  - `out_valid` = 1 and `out_data` = `rx_sr`. Both stay stable until `out_ready` is high.
  - `in_ready` = `out_ready`.
  - `out_ready` = 1 and `in_valid` = 0: go to IDLE.
  - `out_ready` = 1 and `in_valid` = 1: back-to-back case. Accept the new word with the same load actions as IDLE and go directly to SHIFT.
  - `out_ready` = 0: stay in HOLD. Each cycle `in_ready` = 0 and `shift_en` = 0, so the chain is frozen.
- Outside SHIFT:
  - `ser_out` = 0.
  - `ser_in` is ignored.
- `out_valid` = 0 outside HOLD. `out_data` holds the last `rx_sr` in every state.
- A change of `msb_first` during SHIFT/HOLD has no effect on the word in flight.

## Timing
- Reset values: state = IDLE, `tx_sr` = 0, `rx_sr` = 0, `cnt` = 0.
  - Outputs during reset: `in_ready` = 1, `ser_out` = 0, `shift_en` = 0, `out_valid` = 0, `out_data` = 0, `busy` = 0.
- Reset asserted mid-SHIFT or mid-HOLD:
  - All state clears immediately, asynchronously.
  - The in-flight word is dropped and no `out_valid` is produced.
- Acceptance at edge E0 gives exactly `WIDTH` cycles with `shift_en` = 1, sampled at edges E1…E`WIDTH`.
- `out_valid` rises the cycle after edge E`WIDTH`. Minimum TX-accept to RX-valid latency is `WIDTH`+1 cycles.
- Back-to-back with `out_ready` tied high: one word per `WIDTH`+1 cycles, with exactly one non-shift cycle between words.
- `in_ready`, `out_valid` and `shift_en` are decoded from state. The only combinational input-to-output path is `out_ready` → `in_ready` in HOLD.

## Structure
- Shared package `shift_pkg`:
  - state enum `{IDLE, SHIFT, HOLD}`;
  - default `WIDTH` constant.
- One natural sub-module: `shift_bit_sr`, a `WIDTH`-bit bidirectional shift register with load, shift-enable and direction inputs, instantiated twice (TX and RX).
- The FSM and counter live in the top module.

## Test plan
- Direct loopback (`ser_out` → `ser_in`), `WIDTH` = 4, `msb_first` = 1, send 4'b1011 → `ser_out` sequence 1,0,1,1; `out_data` = 4'b1011 with `out_valid` 5 cycles after acceptance.
- Loopback with `msb_first` = 0, send 4'b1011 → `ser_out` sequence 1,1,0,1; `out_data` = 4'b1011.
- External 4-stage SISO chain (`ser_in` = `q4`), chain reset to 0, send 4'hA then 4'h5 back-to-back with `out_ready` = 1:
  - first `out_data` = 4'h0;
  - second `out_data` = 4'hA;
  - exactly one idle cycle between shift bursts.
- Backpressure: hold `out_ready` = 0 for 6 cycles after `out_valid` →
  - `out_data` is stable and `shift_en` = 0 throughout;
  - `in_ready` = 0 even with `in_valid` = 1;
  - the word is released on the first `out_ready` = 1.
- Reset asserted on the 2nd SHIFT cycle → outputs go immediately to reset values and no `out_valid` appears. A word sent after deassertion completes normally.
- Toggle `msb_first` mid-SHIFT → the bit order of the in-flight word is unchanged.
